// File: rtl/instruction_decode.sv
// MIPS decode stage: IF/ID register, decoder, 32x32 register file, load-use/jump detection, ID/EX register.
// Define WB_BYPASS_EN to forward a same-cycle write-back into register-file reads.
module instruction_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [9:0]  PC,
    input  logic        branchFlag,
    input  logic        wbEnable,
    input  logic [4:0]  wbReg,
    input  logic [31:0] wbData,
    output logic        hazardFlag,
    output logic        jumpFlag,
    output logic [9:0]  jumpPC,
    output logic [9:0]  exPC,
    output logic [31:0] exReadData1,
    output logic [31:0] exReadData2,
    output logic [31:0] exImm,
    output logic [4:0]  exRs,
    output logic [4:0]  exRt,
    output logic [4:0]  exRd,
    output logic [5:0]  exFunct,
    output logic [7:0]  exCtrl
);

    localparam int unsigned PC_W   = 10;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned N_REGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control bit positions
    localparam int unsigned C_REGWRITE = 0;
    localparam int unsigned C_MEMREAD  = 1;
    localparam int unsigned C_MEMWRITE = 2;
    localparam int unsigned C_MEMTOREG = 3;
    localparam int unsigned C_ALUSRC   = 4;
    localparam int unsigned C_REGDST   = 5;
    localparam int unsigned C_BRANCH   = 6;
    localparam int unsigned C_ZEROEXT  = 7;

    logic [WORD_W-1:0] r_if_instr;
    logic [PC_W-1:0]   r_if_pc;
    logic              r_if_valid;
    logic [WORD_W-1:0] r_regs [N_REGS];

    logic [5:0]        w_opcode;
    logic [REG_W-1:0]  w_rs;
    logic [REG_W-1:0]  w_rt;
    logic [REG_W-1:0]  w_rd;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_is_jump;
    logic [WORD_W-1:0] w_ext_imm;
    logic [WORD_W-1:0] w_rd1;
    logic [WORD_W-1:0] w_rd2;
    logic              w_load_use;
    logic              w_stall;
    logic              w_bubble;

    assign w_opcode = r_if_instr[31:26];
    assign w_rs     = r_if_instr[25:21];
    assign w_rt     = r_if_instr[20:16];
    assign w_rd     = r_if_instr[15:11];
    assign w_funct  = r_if_instr[5:0];
    assign w_imm    = r_if_instr[15:0];

    // Main decoder; an empty IF/ID slot decodes to all-zero control
    always_comb begin
        w_ctrl    = '0;
        w_is_jump = 1'b0;
        if (r_if_valid) begin
            case (w_opcode)
                OP_RTYPE: begin
                    w_ctrl[C_REGWRITE] = 1'b1;
                    w_ctrl[C_REGDST]   = 1'b1;
                end
                OP_LW: begin
                    w_ctrl[C_REGWRITE] = 1'b1;
                    w_ctrl[C_MEMREAD]  = 1'b1;
                    w_ctrl[C_MEMTOREG] = 1'b1;
                    w_ctrl[C_ALUSRC]   = 1'b1;
                end
                OP_SW: begin
                    w_ctrl[C_MEMWRITE] = 1'b1;
                    w_ctrl[C_ALUSRC]   = 1'b1;
                end
                OP_BEQ:  w_ctrl[C_BRANCH] = 1'b1;
                OP_ADDI: begin
                    w_ctrl[C_REGWRITE] = 1'b1;
                    w_ctrl[C_ALUSRC]   = 1'b1;
                end
                OP_ANDI, OP_ORI: begin
                    w_ctrl[C_REGWRITE] = 1'b1;
                    w_ctrl[C_ALUSRC]   = 1'b1;
                    w_ctrl[C_ZEROEXT]  = 1'b1;
                end
                OP_J:    w_is_jump = 1'b1;
                default: w_ctrl = '0;
            endcase
        end
    end

    assign w_ext_imm = w_ctrl[C_ZEROEXT] ? {16'b0, w_imm} : {{16{w_imm[15]}}, w_imm};

    // Register-file read ports; r0 is hard-wired to zero
    always_comb begin
        w_rd1 = (w_rs == '0) ? '0 : r_regs[w_rs];
        w_rd2 = (w_rt == '0) ? '0 : r_regs[w_rt];
`ifdef WB_BYPASS_EN
        if (wbEnable && (wbReg != '0) && (wbReg == w_rs)) w_rd1 = wbData;
        if (wbEnable && (wbReg != '0) && (wbReg == w_rt)) w_rd2 = wbData;
`endif
    end

    // A taken branch outranks the load-use stall, which outranks a jump
    assign w_load_use = r_if_valid & exCtrl[C_MEMREAD] & (exRt != '0) &
                        ((exRt == w_rs) | (exRt == w_rt));
    assign w_stall    = w_load_use & ~branchFlag;
    assign w_bubble   = branchFlag | w_stall;
    assign hazardFlag = ~w_stall;
    assign jumpFlag   = w_is_jump & ~w_stall & ~branchFlag;
    assign jumpPC     = r_if_instr[PC_W-1:0];

    // IF/ID pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else if (branchFlag || jumpFlag) begin
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else if (hazardFlag) begin
            r_if_instr <= Instruction;
            r_if_pc    <= PC;
            r_if_valid <= 1'b1;
        end
    end

    // Register file, written by write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_REGS); i++) r_regs[i] <= '0;
        end else if (wbEnable && (wbReg != '0)) begin
            r_regs[wbReg] <= wbData;
        end
    end

    // ID/EX pipeline register; stall and flush insert an all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exPC        <= '0;
            exReadData1 <= '0;
            exReadData2 <= '0;
            exImm       <= '0;
            exRs        <= '0;
            exRt        <= '0;
            exRd        <= '0;
            exFunct     <= '0;
            exCtrl      <= '0;
        end else if (w_bubble) begin
            exPC        <= '0;
            exReadData1 <= '0;
            exReadData2 <= '0;
            exImm       <= '0;
            exRs        <= '0;
            exRt        <= '0;
            exRd        <= '0;
            exFunct     <= '0;
            exCtrl      <= '0;
        end else begin
            exPC        <= r_if_pc;
            exReadData1 <= w_rd1;
            exReadData2 <= w_rd2;
            exImm       <= w_ext_imm;
            exRs        <= w_rs;
            exRt        <= w_rt;
            exRd        <= w_rd;
            exFunct     <= w_funct;
            exCtrl      <= w_ctrl;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: vector table through a scoreboard plus hazard/jump/flush/reset sequences.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [9:0]  PC;
    logic        branchFlag;
    logic        wbEnable;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        hazardFlag;
    logic        jumpFlag;
    logic [9:0]  jumpPC;
    logic [9:0]  exPC;
    logic [31:0] exReadData1;
    logic [31:0] exReadData2;
    logic [31:0] exImm;
    logic [4:0]  exRs;
    logic [4:0]  exRt;
    logic [4:0]  exRd;
    logic [5:0]  exFunct;
    logic [7:0]  exCtrl;

    instruction_decode dut (
        .clk(clk), .reset(reset), .Instruction(Instruction), .PC(PC),
        .branchFlag(branchFlag), .wbEnable(wbEnable), .wbReg(wbReg), .wbData(wbData),
        .hazardFlag(hazardFlag), .jumpFlag(jumpFlag), .jumpPC(jumpPC), .exPC(exPC),
        .exReadData1(exReadData1), .exReadData2(exReadData2), .exImm(exImm),
        .exRs(exRs), .exRt(exRt), .exRd(exRd), .exFunct(exFunct), .exCtrl(exCtrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc;
        logic [7:0]  ctrl;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } vec_t;

    localparam logic [31:0] I_LW_R2   = 32'h8C22_0004;
    localparam logic [31:0] I_ADD_R4  = 32'h0042_2020;
    localparam logic [31:0] I_ADD_R3  = 32'h00A0_1820;
    localparam logic [31:0] I_J155    = 32'h0800_0155;
    localparam logic [31:0] I_ADDI_R9 = 32'h2009_8001;
    localparam logic [31:0] I_ORI_R9  = 32'h3409_8001;
    localparam logic [31:0] I_OR_R8   = 32'h00E0_4025;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [8];
    vec_t sb [$];
    vec_t exp_v;
    logic [31:0] exp_bypass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wbEnable = 1'b1;
        wbReg    = a;
        wbData   = d;
        step();
        wbEnable = 1'b0;
    endtask

    task automatic cmp_vec(input vec_t v);
        logic [31:0] w;
        w = v.instr;
        chk("ctrl",  32'(exCtrl), 32'(v.ctrl));
        chk("imm",   exImm, v.imm);
        chk("rd1",   exReadData1, v.rd1);
        chk("rd2",   exReadData2, v.rd2);
        chk("pc",    32'(exPC), 32'(v.pc));
        chk("rs",    32'(exRs), 32'(w[25:21]));
        chk("rt",    32'(exRt), 32'(w[20:16]));
        chk("rd",    32'(exRd), 32'(w[15:11]));
        chk("funct", 32'(exFunct), 32'(w[5:0]));
    endtask

    initial begin
        reset = 1'b1; Instruction = '0; PC = '0; branchFlag = 1'b0;
        wbEnable = 1'b0; wbReg = '0; wbData = '0;

        vecs[0] = '{I_ADD_R3,     10'h010, 8'h21, 32'h0000_1820, 32'h0000_1234, 32'h0};
        vecs[1] = '{I_LW_R2,      10'h011, 8'h1B, 32'h0000_0004, 32'h0000_0100, 32'h0000_00A2};
        vecs[2] = '{32'hAC25_0008, 10'h012, 8'h14, 32'h0000_0008, 32'h0000_0100, 32'h0000_1234};
        vecs[3] = '{I_ORI_R9,     10'h013, 8'h91, 32'h0000_8001, 32'h0,         32'h0};
        vecs[4] = '{I_ADDI_R9,    10'h014, 8'h11, 32'hFFFF_8001, 32'h0,         32'h0};
        vecs[5] = '{32'h30AA_FFFF, 10'h015, 8'h91, 32'h0000_FFFF, 32'h0000_1234, 32'h0};
        vecs[6] = '{32'h10A1_FFFF, 10'h016, 8'h40, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_0100};
        vecs[7] = '{32'hFC85_1234, 10'h017, 8'h00, 32'h0000_1234, 32'h0,         32'h0000_1234};

        @(negedge clk); @(negedge clk);
        chk("rst_hazard", 32'(hazardFlag), 32'd1);
        chk("rst_jump",   32'(jumpFlag), 32'd0);
        chk("rst_ctrl",   32'(exCtrl), 32'd0);
        chk("rst_pc",     32'(exPC), 32'd0);
        chk("rst_rd1",    exReadData1, 32'd0);
        reset = 1'b0;

        wb_write(5'd1, 32'h0000_0100);
        wb_write(5'd2, 32'h0000_00A2);
        wb_write(5'd5, 32'h0000_1234);
        wb_write(5'd0, 32'hFFFF_FFFF);

        // Table: each word reaches ID/EX one step after it enters IF/ID
        for (int i = 0; i < 8; i++) begin
            Instruction = vecs[i].instr;
            PC          = vecs[i].pc;
            sb.push_back(vecs[i]);
            step();
            chk("tbl_hazard", 32'(hazardFlag), 32'd1);
            if (i > 0) begin
                exp_v = sb.pop_front();
                cmp_vec(exp_v);
            end
        end
        Instruction = '0; PC = '0;
        step();
        exp_v = sb.pop_front();
        cmp_vec(exp_v);

        // Load-use: one stall cycle, one bubble, then the dependent add
        Instruction = I_LW_R2;  PC = 10'h040; step();
        Instruction = I_ADD_R4; PC = 10'h041; step();
        chk("lu_hazard0", 32'(hazardFlag), 32'd0);
        chk("lu_lw_ctrl", 32'(exCtrl), 32'h1B);
        chk("lu_jump",    32'(jumpFlag), 32'd0);
        Instruction = '0; PC = 10'h042; step();
        chk("lu_bubble",  32'(exCtrl), 32'd0);
        chk("lu_bub_pc",  32'(exPC), 32'd0);
        chk("lu_hazard1", 32'(hazardFlag), 32'd1);
        step();
        chk("lu_add_ctrl", 32'(exCtrl), 32'h21);
        chk("lu_add_pc",   32'(exPC), 32'h041);
        chk("lu_add_rd",   32'(exRd), 32'd4);
        chk("lu_add_rd1",  exReadData1, 32'h0000_00A2);

        // Jump: squash the word behind the J, then the target flows through
        Instruction = I_J155; PC = 10'h050; step();
        chk("j_flag",   32'(jumpFlag), 32'd1);
        chk("j_pc",     32'(jumpPC), 32'h155);
        chk("j_hazard", 32'(hazardFlag), 32'd1);
        Instruction = I_ADD_R3; PC = 10'h051; step();
        chk("j_flag_off", 32'(jumpFlag), 32'd0);
        chk("j_ex_ctrl",  32'(exCtrl), 32'd0);
        Instruction = I_ADDI_R9; PC = 10'h156; step();
        chk("j_squash_ctrl", 32'(exCtrl), 32'd0);
        chk("j_squash_pc",   32'(exPC), 32'd0);
        Instruction = '0; PC = '0; step();
        chk("j_tgt_ctrl", 32'(exCtrl), 32'h11);
        chk("j_tgt_pc",   32'(exPC), 32'h156);
        chk("j_tgt_imm",  exImm, 32'hFFFF_8001);

        // Branch flush coincident with a load-use stall
        Instruction = I_LW_R2;  PC = 10'h060; step();
        Instruction = I_ADD_R4; PC = 10'h061; step();
        chk("br_stall", 32'(hazardFlag), 32'd0);
        branchFlag = 1'b1;
        #1;
        chk("br_hazard", 32'(hazardFlag), 32'd1);
        chk("br_jump",   32'(jumpFlag), 32'd0);
        Instruction = I_ADD_R3; PC = 10'h062; step();
        branchFlag = 1'b0;
        chk("br_ex_ctrl", 32'(exCtrl), 32'd0);
        chk("br_ex_pc",   32'(exPC), 32'd0);
        chk("br_ex_rt",   32'(exRt), 32'd0);
        Instruction = I_ORI_R9; PC = 10'h070; step();
        chk("br_ifid_nop", 32'(exCtrl), 32'd0);
        chk("br_ifid_pc",  32'(exPC), 32'd0);
        Instruction = '0; PC = '0; step();
        chk("br_tgt_ctrl", 32'(exCtrl), 32'h91);
        chk("br_tgt_pc",   32'(exPC), 32'h070);

        // Write-back of r7 in the same cycle that reads it
`ifdef WB_BYPASS_EN
        exp_bypass = 32'hDEAD_BEEF;
`else
        exp_bypass = 32'h0;
`endif
        Instruction = I_OR_R8; PC = 10'h080; step();
        wbEnable = 1'b1; wbReg = 5'd7; wbData = 32'hDEAD_BEEF;
        Instruction = '0; PC = '0; step();
        wbEnable = 1'b0;
        chk("wb_same_cycle", exReadData1, exp_bypass);
        chk("wb_or_ctrl",    32'(exCtrl), 32'h21);
        Instruction = I_OR_R8; PC = 10'h081; step();
        Instruction = '0; PC = '0; step();
        chk("wb_later", exReadData1, 32'hDEAD_BEEF);

        // Asynchronous reset mid-operation clears pipeline and register file
        Instruction = I_ADD_R3; PC = 10'h090; step();
        Instruction = '0; PC = '0; step();
        chk("ar_pre_rd1", exReadData1, 32'h0000_1234);
        #2 reset = 1'b1;
        #1;
        chk("ar_ctrl",   32'(exCtrl), 32'd0);
        chk("ar_rd1",    exReadData1, 32'd0);
        chk("ar_pc",     32'(exPC), 32'd0);
        chk("ar_hazard", 32'(hazardFlag), 32'd1);
        reset = 1'b0;
        Instruction = I_ADD_R3; PC = 10'h091; step();
        Instruction = '0; PC = '0; step();
        chk("ar_post_ctrl", 32'(exCtrl), 32'h21);
        chk("ar_post_rd1",  exReadData1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the MIPS core, directly downstream of the instruction-fetch stage. Holds the IF/ID register, decodes the instruction, reads a 32×32 register file (written by write-back), and latches operands and control into the ID/EX register. Detects load-use hazards and J-type jumps, and drives `hazardFlag`, `jumpFlag` and `jumpPC` back to fetch. Flushes on `branchFlag` from EX.

## Interface
Parameters:
- None. Widths are fixed: PC 10 bits, word 32 bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `Instruction`  in  32  instruction word from fetch
- `PC`  in  10  PC of the instruction after `Instruction`
- `branchFlag`  in  1  taken branch resolved in EX; flush request
- `wbEnable`  in  1  register-file write enable from write-back
- `wbReg`  in  5  write-back destination register
- `wbData`  in  32  write-back data
- `hazardFlag`  out  1  1 = fetch may advance; 0 = stall (freeze PC)
- `jumpFlag`  out  1  J instruction in IF/ID; redirect fetch
- `jumpPC`  out  10  jump target, `Instruction[9:0]` of the IF/ID word
- `exPC`  out  10  ID/EX PC
- `exReadData1`, `exReadData2`  out  32 each  ID/EX rs and rt operands
- `exImm`  out  32  ID/EX immediate, sign- or zero-extended
- `exRs`, `exRt`, `exRd`  out  5 each  ID/EX register fields
- `exFunct`  out  6  ID/EX funct field
- `exCtrl`  out  8  ID/EX control: [0] regWrite, [1] memRead, [2] memWrite, [3] memToReg, [4] aluSrc, [5] regDst, [6] branch, [7] zeroExt

## Operation
- **IF/ID register** (`ifInstr`, `ifPC`, `ifValid`):
  - Reset → 0 / 0 / 0.
  - Loads `Instruction`/`PC` with `ifValid=1` when `hazardFlag=1`; holds when `hazardFlag=0`.
  - Loaded with NOP (all zero, `ifValid=0`) when `branchFlag=1` or `jumpFlag=1`.
- **Decode** (combinational from IF/ID; applies only when `ifValid=1`, otherwise all-zero control):
  - `000000` R-type: regWrite, regDst
  - `100011` lw: regWrite, memRead, memToReg, aluSrc
  - `101011` sw: memWrite, aluSrc
  - `000100` beq: branch
  - `001000` addi: regWrite, aluSrc
  - `001100` andi / `001101` ori: regWrite, aluSrc, zeroExt
  - `000010` j: control all zero; asserts `jumpFlag`
  - any other opcode: all-zero control (NOP)
- **Immediate:** `exImm` = `{16{imm[15]}, imm}`, or `{16'b0, imm}` when zeroExt.
- **Register file:**
  - Write on rising edge when `wbEnable` and `wbReg != 0`.
  - r0 always reads 0. Reset clears all 32 entries.
- **Load-use hazard:** stall = `ifValid` & `exCtrl[1]` & `exRt != 0` & (`exRt == rs` or `exRt == rt`) of the IF/ID word.
  - `hazardFlag = ~stall`.
  - During a stall, ID/EX loads a bubble (all fields zero).
- **Priority** (highest first): `branchFlag` > stall > `jumpFlag`.
  - `jumpFlag = ifValid & opcode==000010 & ~stall & ~branchFlag`.
  - On `branchFlag`, ID/EX also loads a bubble.

## Timing
- All outputs are 0 in reset, except `hazardFlag`, which is 1 in reset.
- Instruction presented at edge N → IF/ID at N → ID/EX outputs valid after edge N+1. Latency is 1 cycle per stage.
- `hazardFlag`, `jumpFlag`, `jumpPC` are combinational from IF/ID and ID/EX state, valid before the next edge.
- Load-use stall lasts exactly 1 cycle. The bubble clears `exCtrl[1]`, so the stall condition drops.
- Jump: the word fetched behind a J is squashed. IF/ID holds NOP for 1 cycle, then holds the target instruction.
- `reset` asserted mid-operation clears IF/ID, ID/EX and the register file immediately, without waiting for a clock edge.

## Configuration
- `WB_BYPASS_EN` defined:
  - A read whose address equals `wbReg` with `wbEnable=1` (nonzero address) returns `wbData` in the same cycle (write-first).
- Undefined:
  - Reads return the stored value. The same-cycle write is visible only to instructions decoded on later cycles; software must insert a NOP.

## Test plan
- Reset, then write r5=0x0000_1234 via WB; decode `add r3,r5,r0` → `exReadData1=0x1234`, `exCtrl=0x21`, `hazardFlag=1`.
- `lw r2,4(r1)` followed by `add r4,r2,r2` → `hazardFlag=0` for exactly 1 cycle; bubble in ID/EX (`exCtrl=0`); add reaches ID/EX 1 cycle later.
- `j 0x155` in IF/ID → `jumpFlag=1`, `jumpPC=0x155`; next cycle IF/ID is NOP and `exCtrl=0`.
- `branchFlag=1` coincident with load-use stall → IF/ID and ID/EX both NOP, `hazardFlag=1`, `jumpFlag=0`.
- WB writes r7=0xDEADBEEF while `or r8,r7,r0` decodes:
  - with `WB_BYPASS_EN`, `exReadData1=0xDEADBEEF`;
  - without it, the old value (0).
- `ori r9,r0,0x8001` → `exImm=0x0000_8001`; `addi r9,r0,0x8001` → `exImm=0xFFFF_8001`; a WB write to r0 leaves r0 reading 0.
